// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: reset PC, NOP encoding and the IF/ID payload layout.
// Anything crossing the fetch/decode boundary should come from here.
package riscv_pkg;

   localparam logic [31:0] NOP_INST           = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;
   localparam int unsigned IMEM_DEPTH_DEFAULT = 25501;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
   } if_id_t;

   // A bubble carries a NOP so decode sees a harmless instruction even if valid is ignored.
   localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise the contents hold.
// Asynchronous reset returns it to the bubble value.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= IF_ID_BUBBLE;
      end else if (bubble) begin
         q <= IF_ID_BUBBLE;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the combinational instruction memory and fills IF/ID.
// Redirect beats stall beats normal fetch; an out-of-range PC parks the stage until redirect.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [29:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_inst_o,
   output logic        if_id_valid_o,
   output logic        misalign_o,
   output logic        fetch_fault_o,
   output logic [31:0] fetch_count_o
);

   localparam logic [0:0] ST_FETCH  = 1'b0;
   localparam logic [0:0] ST_PARKED = 1'b1;

   logic [31:0] pc_q;
   logic [31:0] pc_offset;
   logic [31:0] word_idx;
   logic        oob;
   logic        do_fetch;
   logic        do_park;
   logic [0:0]  state_q;
   logic        misalign_q;
   logic        fault_q;
   logic [31:0] count_q;
   if_id_t      if_id_d;
   if_id_t      if_id_q;

   // A PC below RESET_PC wraps to a huge offset, so it lands out of range as well.
   assign pc_offset   = pc_q - RESET_PC;
   assign word_idx    = pc_offset >> 2;
   assign oob         = (word_idx >= IMEM_DEPTH);
   assign imem_addr_o = word_idx[29:0];

   assign do_fetch = !redirect_i && !stall_i && !oob;
   assign do_park  = !redirect_i && !stall_i && oob;

   assign if_id_d = '{pc: pc_q, inst: imem_data_i, valid: 1'b1};

   if_id_reg u_if_id_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (do_fetch),
      .bubble (redirect_i || do_park),
      .d      (if_id_d),
      .q      (if_id_q)
   );

   // The fault pulse fires only on the edge that enters the parked state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         state_q    <= ST_FETCH;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
         count_q    <= 32'h0;
      end else begin
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
         if (redirect_i) begin
            pc_q       <= {redirect_pc_i[31:2], 2'b00};
            misalign_q <= (redirect_pc_i[1:0] != 2'b00);
            state_q    <= ST_FETCH;
         end else if (stall_i) begin
            pc_q <= pc_q;
         end else if (oob) begin
            fault_q <= (state_q == ST_FETCH);
            state_q <= ST_PARKED;
         end else begin
            pc_q    <= pc_q + 32'd4;
            count_q <= count_q + 32'd1;
         end
      end
   end

   assign if_id_pc_o    = if_id_q.pc;
   assign if_id_inst_o  = if_id_q.inst;
   assign if_id_valid_o = if_id_q.valid;
   assign misalign_o    = misalign_q;
   assign fetch_fault_o = fault_q;
   assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID loads, a negedge monitor pops them.
// Memory word n holds 0xA0 + n; beyond the end it returns a poison pattern.
module tb_fetch_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [29:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_inst_o;
   logic        if_id_valid_o;
   logic        misalign_o;
   logic        fetch_fault_o;
   logic [31:0] fetch_count_o;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   logic [31:0] last_count = 32'h0;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .if_id_pc_o    (if_id_pc_o),
      .if_id_inst_o  (if_id_inst_o),
      .if_id_valid_o (if_id_valid_o),
      .misalign_o    (misalign_o),
      .fetch_fault_o (fetch_fault_o),
      .fetch_count_o (fetch_count_o)
   );

   assign imem_data_i = (imem_addr_o < 30'd25501) ? (32'h0000_00A0 + {2'b00, imem_addr_o})
                                                  : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Inputs change just after a negedge; returns one full cycle later, after the monitor ran.
   task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target);
      stall_i       = stall;
      redirect_i    = redir;
      redirect_pc_i = target;
      @(negedge clk);
      #1;
   endtask

   task automatic expectLoad(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, {31'h0, if_id_valid_o}, 32'h0);
      checkOutput({tag, "_inst"}, if_id_inst_o, 32'h0000_0013);
      checkOutput({tag, "_pc"}, if_id_pc_o, 32'h0);
      checkOutput({tag, "_count"}, fetch_count_o, 32'h0);
      checkOutput({tag, "_addr"}, {2'b00, imem_addr_o}, 32'h0);
      checkOutput({tag, "_misalign"}, {31'h0, misalign_o}, 32'h0);
      checkOutput({tag, "_fault"}, {31'h0, fetch_fault_o}, 32'h0);
   endtask

   // A fresh load is recognised by the fetch counter moving while IF/ID is valid.
   always @(negedge clk) begin
      if (!rst && if_id_valid_o && fetch_count_o != last_count) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected: got pc 0x%08h inst 0x%08h expected no load",
                     if_id_pc_o, if_id_inst_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (if_id_pc_o !== e.pc || if_id_inst_o !== e.inst) begin
               failures++;
               $display("[TB] FAIL sb_load: got pc 0x%08h inst 0x%08h expected pc 0x%08h inst 0x%08h",
                        if_id_pc_o, if_id_inst_o, e.pc, e.inst);
            end
         end
      end
      last_count = fetch_count_o;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;

      // Two sequential fetches, then a 3-cycle stall at pc 0x80000008.
      expectLoad(32'h8000_0000, 32'hA0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("seq_addr1", {2'b00, imem_addr_o}, 32'd1);
      checkOutput("seq_valid1", {31'h0, if_id_valid_o}, 32'h1);
      expectLoad(32'h8000_0004, 32'hA1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("seq_addr2", {2'b00, imem_addr_o}, 32'd2);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("stall_addr", {2'b00, imem_addr_o}, 32'd2);
         checkOutput("stall_pc", if_id_pc_o, 32'h8000_0004);
         checkOutput("stall_count", fetch_count_o, 32'd2);
      end
      expectLoad(32'h8000_0008, 32'hA2);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("seq_addr3", {2'b00, imem_addr_o}, 32'd3);
      expectLoad(32'h8000_000C, 32'hA3);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("seq_count4", fetch_count_o, 32'd4);

      // Redirect wins over stall and inserts a bubble.
      applyStimulus(1'b1, 1'b1, 32'h8000_0040);
      checkOutput("redir_valid", {31'h0, if_id_valid_o}, 32'h0);
      checkOutput("redir_inst", if_id_inst_o, 32'h0000_0013);
      checkOutput("redir_addr", {2'b00, imem_addr_o}, 32'd16);
      checkOutput("redir_count", fetch_count_o, 32'd4);
      checkOutput("redir_misalign", {31'h0, misalign_o}, 32'h0);
      expectLoad(32'h8000_0040, 32'hB0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("redir_count5", fetch_count_o, 32'd5);

      // Misaligned target: low bits dropped, one-cycle misalign pulse.
      applyStimulus(1'b0, 1'b1, 32'h8000_0046);
      checkOutput("mis_addr", {2'b00, imem_addr_o}, 32'd17);
      checkOutput("mis_pulse", {31'h0, misalign_o}, 32'h1);
      expectLoad(32'h8000_0044, 32'hB1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("mis_clear", {31'h0, misalign_o}, 32'h0);

      // Last word in range, then park on the first out-of-range word.
      applyStimulus(1'b0, 1'b1, 32'h8001_8E70);
      checkOutput("end_addr", {2'b00, imem_addr_o}, 32'd25500);
      expectLoad(32'h8001_8E70, 32'h0000_643C);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("end_count", fetch_count_o, 32'd7);
      checkOutput("end_fault0", {31'h0, fetch_fault_o}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("oob_fault", {31'h0, fetch_fault_o}, 32'h1);
      checkOutput("oob_valid", {31'h0, if_id_valid_o}, 32'h0);
      checkOutput("oob_addr", {2'b00, imem_addr_o}, 32'd25501);
      checkOutput("oob_count", fetch_count_o, 32'd7);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("park_fault", {31'h0, fetch_fault_o}, 32'h0);
      checkOutput("park_addr", {2'b00, imem_addr_o}, 32'd25501);
      checkOutput("park_count", fetch_count_o, 32'd7);
      applyStimulus(1'b0, 1'b1, 32'h8000_0000);
      checkOutput("resume_addr", {2'b00, imem_addr_o}, 32'd0);
      expectLoad(32'h8000_0000, 32'hA0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("resume_count", fetch_count_o, 32'd8);
      checkOutput("resume_valid", {31'h0, if_id_valid_o}, 32'h1);

      // Asynchronous reset mid-cycle, well away from any clock edge.
      #2;
      rst = 1'b1;
      #1;
      checkResetState("async");
      @(negedge clk);
      #1;
      rst = 1'b0;
      expectLoad(32'h8000_0000, 32'hA0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("post_rst_count", fetch_count_o, 32'd1);

      checkOutput("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
